// File: rtl/vending_pkg.sv
// Shared types and constants for the vending output stage.
package vending_pkg;

  localparam logic [2:0] CHG_0  = 3'd0;
  localparam logic [2:0] CHG_5  = 3'd1;
  localparam logic [2:0] CHG_10 = 3'd2;
  localparam logic [2:0] CHG_15 = 3'd3;
  localparam logic [2:0] CHG_20 = 3'd4;

  typedef enum logic [2:0] {
    IDLE,
    VEND,
    VEND_WAIT,
    COIN,
    COIN_WAIT,
    DONE
  } disp_state_t;

  localparam int unsigned ERR_W     = 4;
  localparam int unsigned ERR_OVF   = 0;
  localparam int unsigned ERR_TMO   = 1;
  localparam int unsigned ERR_CODE  = 2;
  localparam int unsigned ERR_SHORT = 3;

  // Codes above 20 cents are treated as no change.
  function automatic logic [2:0] chg_sanitize(input logic [2:0] code);
    return (code > CHG_20) ? CHG_0 : code;
  endfunction

endpackage

// File: rtl/ack_timer.sv
// Wait-state watchdog: counts cycles while enabled, flags expiry after ACK_TIMEOUT cycles.
module ack_timer #(
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter int unsigned TMR_W       = 5
) (
  input  logic clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired_c
);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  // Count saturates at the expiry value so it never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en && !o_expired_c) begin
      cnt_d = cnt_q + TMR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_expired_c = (cnt_q == TMR_W'(ACK_TIMEOUT - 1));

endmodule

// File: rtl/change_dispenser.sv
// Vend actuator + change hopper sequencer with one-deep request buffer,
// per-item ack handshake, ack watchdog and sticky error flags.
module change_dispenser
  import vending_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter int unsigned TMR_W       = 5
) (
  input  logic       clk,
  input  logic       i_rst,
  input  logic       i_soda,
  input  logic [2:0] i_change,
  input  logic       i_vend_ack,
  input  logic       i_coin_ack,
  input  logic       i_dime_empty,
  input  logic       i_nickel_empty,
  output logic       o_vend,
  output logic       o_eject_dime,
  output logic       o_eject_nickel,
  output logic       o_busy,
  output logic       o_done,
  output logic [3:0] o_err
);

  disp_state_t      state_q, state_d;
  logic [2:0]       rem_q, rem_d;
  logic [2:0]       pend_code_q, pend_code_d;
  logic             pend_vld_q, pend_vld_d;
  logic             vend_q, vend_d;
  logic             dime_q, dime_d;
  logic             nickel_q, nickel_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic [ERR_W-1:0] err_q, err_d;

  logic       in_wait_c, ack_ok_c, expired_c, to_pend_c;
  logic [2:0] code_c;

  assign in_wait_c = (state_q == VEND_WAIT) || (state_q == COIN_WAIT);
  // An ack arriving while the request pulse is still on the wire is not trusted.
  assign ack_ok_c  = !(vend_q || dime_q || nickel_q);
  assign code_c    = chg_sanitize(i_change);
  // DONE with an empty slot takes the new request directly as the active one.
  assign to_pend_c = i_soda && (state_q != IDLE) && !((state_q == DONE) && !pend_vld_q);

  ack_timer #(
    .ACK_TIMEOUT(ACK_TIMEOUT),
    .TMR_W      (TMR_W)
  ) u_ack_timer (
    .clk        (clk),
    .i_rst      (i_rst),
    .i_clr      (!in_wait_c),
    .i_en       (in_wait_c),
    .o_expired_c(expired_c)
  );

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    pend_code_d = pend_code_q;
    pend_vld_d  = pend_vld_q;
    vend_d      = 1'b0;
    dime_d      = 1'b0;
    nickel_d    = 1'b0;
    done_d      = 1'b0;
    err_d       = err_q;

    if (i_soda && (i_change > CHG_20)) begin
      err_d[ERR_CODE] = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (i_soda) begin
          rem_d   = code_c;
          state_d = VEND;
        end
      end
      VEND: begin
        vend_d  = 1'b1;
        state_d = VEND_WAIT;
      end
      VEND_WAIT: begin
        if (i_vend_ack && ack_ok_c) begin
          state_d = COIN;
        end else if (expired_c) begin
          err_d[ERR_TMO] = 1'b1;
          state_d        = COIN;
        end
      end
      COIN: begin
        if (rem_q == 3'd0) begin
          state_d = DONE;
        end else if ((rem_q >= 3'd2) && !i_dime_empty) begin
          dime_d  = 1'b1;
          rem_d   = rem_q - 3'd2;
          state_d = COIN_WAIT;
        end else if (!i_nickel_empty) begin
          nickel_d = 1'b1;
          rem_d    = rem_q - 3'd1;
          state_d  = COIN_WAIT;
        end else begin
          err_d[ERR_SHORT] = 1'b1;
          rem_d            = 3'd0;
          state_d          = DONE;
        end
      end
      COIN_WAIT: begin
        if (i_coin_ack && ack_ok_c) begin
          state_d = COIN;
        end else if (expired_c) begin
          err_d[ERR_TMO] = 1'b1;
          state_d        = COIN;
        end
      end
      DONE: begin
        done_d = 1'b1;
        if (pend_vld_q) begin
          rem_d      = pend_code_q;
          pend_vld_d = 1'b0;
          state_d    = VEND;
        end else if (i_soda) begin
          rem_d   = code_c;
          state_d = VEND;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Pending slot: a slot freed on this edge can be refilled on the same edge.
    if (to_pend_c) begin
      if (!pend_vld_d) begin
        pend_vld_d  = 1'b1;
        pend_code_d = code_c;
      end else begin
        err_d[ERR_OVF] = 1'b1;
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      rem_q       <= 3'd0;
      pend_code_q <= 3'd0;
      pend_vld_q  <= 1'b0;
      vend_q      <= 1'b0;
      dime_q      <= 1'b0;
      nickel_q    <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      pend_code_q <= pend_code_d;
      pend_vld_q  <= pend_vld_d;
      vend_q      <= vend_d;
      dime_q      <= dime_d;
      nickel_q    <= nickel_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign o_vend         = vend_q;
  assign o_eject_dime   = dime_q;
  assign o_eject_nickel = nickel_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;
  assign o_err          = err_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: a timeline model plans every request's pulses and
// ack edges up front, then the DUT is compared against it after every clock edge.
module tb_change_dispenser;
  import vending_pkg::*;

  localparam int TO   = 16;
  localparam int MAXE = 2048;

  logic       clk = 1'b0;
  logic       i_rst, i_soda, i_vend_ack, i_coin_ack, i_dime_empty, i_nickel_empty;
  logic [2:0] i_change;
  logic       o_vend, o_eject_dime, o_eject_nickel, o_busy, o_done;
  logic [3:0] o_err;

  always #5 clk = ~clk;

  change_dispenser #(.ACK_TIMEOUT(TO), .TMR_W(5)) dut (
    .clk           (clk),
    .i_rst         (i_rst),
    .i_soda        (i_soda),
    .i_change      (i_change),
    .i_vend_ack    (i_vend_ack),
    .i_coin_ack    (i_coin_ack),
    .i_dime_empty  (i_dime_empty),
    .i_nickel_empty(i_nickel_empty),
    .o_vend        (o_vend),
    .o_eject_dime  (o_eject_dime),
    .o_eject_nickel(o_eject_nickel),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_err         (o_err)
  );

  // Per-edge stimulus (value sampled at edge e) and expected outputs (visible after edge e).
  bit       st_rst[MAXE], st_soda[MAXE], st_vack[MAXE], st_cack[MAXE];
  bit [2:0] st_chg[MAXE];
  bit       st_de, st_ne;
  bit       ex_vend[MAXE], ex_dime[MAXE], ex_nick[MAXE], ex_done[MAXE], ex_busy[MAXE];
  bit [3:0] ex_errset[MAXE];
  bit [8:0] obs[MAXE];

  int tests = 0;
  int fails = 0;
  int scen  = 0;

  // Model bookkeeping: active request ends (DONE state) after edge act_end.
  bit act, pnd;
  int act_end, pnd_code, hi, fixed_vd, fixed_cd;

  function automatic int pick_delay(input int fixed);
    int r;
    if (fixed >= 0) return fixed;
    r = int'($urandom_range(0, 11));
    if (r == 0) return 0;
    if (r == 1) return 1;
    if (r == 2) return TO;
    if (r == 3) return TO + 1;
    return int'($urandom_range(2, 6));
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Ack d edges after the pulse edge p; d==0 means the ack never comes.
  task automatic plan_wait(input int p, input int d, input bit is_coin, output int x);
    if (d >= 1) begin
      if (is_coin) st_cack[p + d] = 1'b1;
      else         st_vack[p + d] = 1'b1;
      hi = max2(hi, p + d);
    end
    if (d >= 2 && d <= TO) begin
      x = p + d;
    end else begin
      x = p + TO;
      ex_errset[x][ERR_TMO] = 1'b1;
    end
  endtask

  task automatic start_req(input int s, input int code);
    int x, rem;
    ex_vend[s + 1] = 1'b1;
    plan_wait(s + 1, pick_delay(fixed_vd), 1'b0, x);
    rem = code;
    for (int g = 0; g < 8; g++) begin
      x = x + 1;
      if (rem == 0) break;
      if (rem >= 2 && !st_de) begin
        ex_dime[x] = 1'b1;
        rem -= 2;
        plan_wait(x, pick_delay(fixed_cd), 1'b1, x);
      end else if (!st_ne) begin
        ex_nick[x] = 1'b1;
        rem -= 1;
        plan_wait(x, pick_delay(fixed_cd), 1'b1, x);
      end else begin
        ex_errset[x][ERR_SHORT] = 1'b1;
        break;
      end
    end
    for (int e = s; e <= x; e++) ex_busy[e] = 1'b1;
    ex_done[x + 1] = 1'b1;
    act     = 1'b1;
    act_end = x;
    hi      = max2(hi, x + 1);
  endtask

  task automatic advance_to(input int c);
    while (act && (act_end + 1 < c)) begin
      act = 1'b0;
      if (pnd) begin
        pnd = 1'b0;
        start_req(act_end + 1, pnd_code);
      end
    end
  endtask

  task automatic soda_event(input int c, input int raw);
    int code;
    st_soda[c] = 1'b1;
    st_chg[c]  = 3'(raw);
    code = (raw > 4) ? 0 : raw;
    if (raw > 4) ex_errset[c][ERR_CODE] = 1'b1;
    hi = max2(hi, c);
    advance_to(c);
    if (!act) begin
      start_req(c, code);
    end else if (act_end + 1 == c) begin
      if (pnd) begin
        start_req(c, pnd_code);
        pnd_code = code;
      end else begin
        start_req(c, code);
      end
    end else if (!pnd) begin
      pnd      = 1'b1;
      pnd_code = code;
    end else begin
      ex_errset[c][ERR_OVF] = 1'b1;
    end
  endtask

  task automatic reset_event(input int r);
    advance_to(r);
    for (int e = r; e < MAXE; e++) begin
      ex_vend[e] = 0; ex_dime[e] = 0; ex_nick[e] = 0; ex_done[e] = 0; ex_busy[e] = 0;
      ex_errset[e] = '0; st_vack[e] = 0; st_cack[e] = 0;
    end
    st_rst[r] = 1'b1;
    act = 1'b0;
    pnd = 1'b0;
    hi  = max2(hi, r);
  endtask

  task automatic new_scen(input bit de, input bit ne, input int vd, input int cd);
    for (int e = 0; e < MAXE; e++) begin
      st_rst[e] = 0; st_soda[e] = 0; st_vack[e] = 0; st_cack[e] = 0; st_chg[e] = '0;
      ex_vend[e] = 0; ex_dime[e] = 0; ex_nick[e] = 0; ex_done[e] = 0; ex_busy[e] = 0;
      ex_errset[e] = '0; obs[e] = '0;
    end
    st_rst[0] = 1'b1;
    st_de = de; st_ne = ne; fixed_vd = vd; fixed_cd = cd;
    act = 0; pnd = 0; hi = 0;
    scen++;
  endtask

  // Drive the planned stimulus and compare every edge against the plan.
  task automatic run_scen(output int n);
    bit [3:0] errv;
    bit [8:0] exp_v;
    advance_to(1 << 30);
    n    = hi + 4;
    errv = '0;
    for (int e = 0; e <= n; e++) begin
      i_rst = st_rst[e]; i_soda = st_soda[e]; i_change = st_chg[e];
      i_vend_ack = st_vack[e]; i_coin_ack = st_cack[e];
      i_dime_empty = st_de; i_nickel_empty = st_ne;
      @(posedge clk);
      #1;
      obs[e] = {o_vend, o_eject_dime, o_eject_nickel, o_done, o_busy, o_err};
      if (st_rst[e]) errv = '0;
      else           errv = errv | ex_errset[e];
      exp_v = {ex_vend[e], ex_dime[e], ex_nick[e], ex_done[e], ex_busy[e], errv};
      tests++;
      if (obs[e] !== exp_v) begin
        fails++;
        $display("FAIL edge_cmp scen=%0d edge=%0d got vend,dime,nick,done,busy,err=%b expected %b",
                 scen, e, obs[e], exp_v);
      end
    end
  endtask

  task automatic check_lit(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s scen=%0d got %0d expected %0d", name, scen, got, exp);
    end
  endtask

  function automatic int count_bit(input int b, input int from, input int to);
    int c = 0;
    for (int e = from; e <= to; e++) c += int'(obs[e][b]);
    return c;
  endfunction

  initial begin
    int n, raw, c, r;
    i_rst = 1; i_soda = 0; i_change = '0; i_vend_ack = 0; i_coin_ack = 0;
    i_dime_empty = 0; i_nickel_empty = 0;

    // 1: 15 cents, tubes full, acks two edges after each pulse.
    new_scen(0, 0, 2, 2);
    soda_event(1, 3);
    run_scen(n);
    check_lit("t1_reset_state", int'(obs[0]), 0);
    check_lit("t1_vend_edge2", int'(obs[2][8]), 1);
    check_lit("t1_dime_edge5", int'(obs[5][7]), 1);
    check_lit("t1_nickel_edge8", int'(obs[8][6]), 1);
    check_lit("t1_done_edge12", int'(obs[12][5]), 1);
    check_lit("t1_err_clear", int'(obs[12][3:0]), 0);

    // 2: 20 cents with dimes empty -> four nickels.
    new_scen(1, 0, 2, 2);
    soda_event(1, 4);
    run_scen(n);
    check_lit("t2_nickels", count_bit(6, 0, n), 4);
    check_lit("t2_dimes", count_bit(7, 0, n), 0);
    check_lit("t2_done", count_bit(5, 0, n), 1);

    // 3: 5 cents with nickels empty -> short change.
    new_scen(0, 1, 2, 2);
    soda_event(1, 1);
    run_scen(n);
    check_lit("t3_err_short", int'(obs[5][3:0]), 8);
    check_lit("t3_ejects", count_bit(6, 0, n) + count_bit(7, 0, n), 0);
    check_lit("t3_done_edge6", int'(obs[6][5]), 1);

    // 4: 10 cents, hopper never acks -> timeout 16 cycles after the dime.
    new_scen(0, 0, 2, 0);
    soda_event(1, 2);
    run_scen(n);
    check_lit("t4_dime_edge5", int'(obs[5][7]), 1);
    check_lit("t4_no_tmo_edge20", int'(obs[20][3:0]), 0);
    check_lit("t4_tmo_edge21", int'(obs[21][3:0]), 2);
    check_lit("t4_done_edge23", int'(obs[23][5]), 1);

    // 5: three back-to-back requests, the third overflows.
    new_scen(0, 0, 2, 2);
    soda_event(1, 1);
    soda_event(2, 2);
    soda_event(3, 3);
    run_scen(n);
    check_lit("t5_ovf_edge3", int'(obs[3][3:0]), 1);
    check_lit("t5_done_edge9", int'(obs[9][5]), 1);
    check_lit("t5_busy_edge9", int'(obs[9][4]), 1);
    check_lit("t5_vend_edge10", int'(obs[10][8]), 1);
    check_lit("t5_vends", count_bit(8, 0, n), 2);
    check_lit("t5_done_edge17", int'(obs[17][5]), 1);

    // 6: reset in COIN_WAIT with a pending request, then a no-change vend.
    new_scen(0, 0, 2, 0);
    soda_event(1, 4);
    soda_event(3, 2);
    reset_event(8);
    soda_event(12, 0);
    run_scen(n);
    check_lit("t6_after_reset", int'(obs[8]), 0);
    check_lit("t6_vend_edge13", int'(obs[13][8]), 1);
    check_lit("t6_done_edge17", int'(obs[17][5]), 1);
    check_lit("t6_ejects_after", count_bit(6, 9, n) + count_bit(7, 9, n), 0);

    // Randomized traffic, ack delays, tube levels and occasional resets.
    for (int s = 0; s < 40; s++) begin
      new_scen($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, -1, -1);
      c = 0;
      for (int i = 0; i < int'($urandom_range(1, 6)); i++) begin
        r = int'($urandom_range(0, 3));
        c += (r == 0) ? 1 : (r == 1) ? int'($urandom_range(2, 8)) : int'($urandom_range(10, 60));
        if ($urandom_range(0, 11) == 0) begin
          reset_event(c);
        end else begin
          raw = ($urandom_range(0, 5) == 0) ? int'($urandom_range(5, 7)) : int'($urandom_range(0, 4));
          soda_event(c, raw);
        end
      end
      run_scen(n);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
